demux1to2_fifo: RTL

Registered 32-bit 1-to-2 stream demultiplexer: accepts one word per cycle on a single valid/ready input port and steers it, by a per-word select bit, into one of two independent output FIFOs, each drained by its own valid/ready consumer. It is the inverse-direction companion of the 32-bit 2-to-1 select mux. It sits where one producer must feed two datapath consumers that stall independently, such as a writeback path split between the register file and a store buffer. Per-output delivered-word counters support debug and verification.

---
 rtl/demux1to2_fifo.sv | 86 ++++++++
 1 files changed

// File: rtl/demux1to2_fifo.sv
// 1-to-2 stream demultiplexer: each input word is steered by in_sel into one of
// two independent circular FIFOs, each drained by its own valid/ready consumer.
module demux1to2_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [CNTW-1:0]  out0_cnt,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNTW-1:0]  out1_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem  [2][DEPTH];
  logic [AW-1:0]    wptr [2];
  logic [AW-1:0]    rptr [2];
  logic [AW:0]      occ  [2];
  logic [CNTW-1:0]  cnt  [2];

  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;

  // A full port refuses a word even while it pops in the same cycle: no bypass.
  always_comb begin
    full[0]  = (occ[0] == FULL_OCC);
    full[1]  = (occ[1] == FULL_OCC);
    in_ready = in_sel ? !full[1] : !full[0];
    push[0]  = in_valid && !in_sel && !full[0];
    push[1]  = in_valid &&  in_sel && !full[1];
    pop[0]   = (occ[0] != '0) && out0_ready;
    pop[1]   = (occ[1] != '0) && out1_ready;
  end

  assign out0_valid = (occ[0] != '0);
  assign out1_valid = (occ[1] != '0);
  assign out0_data  = mem[0][rptr[0]];
  assign out1_data  = mem[1][rptr[1]];
  assign out0_cnt   = cnt[0];
  assign out1_cnt   = cnt[1];

  // Pointers are AW bits wide, so DEPTH being a power of two gives the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        wptr[p] <= '0;
        rptr[p] <= '0;
        occ[p]  <= '0;
        cnt[p]  <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem[p][i] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) begin
          mem[p][wptr[p]] <= in_data;
          wptr[p]         <= wptr[p] + 1'b1;
        end
        if (pop[p]) begin
          rptr[p] <= rptr[p] + 1'b1;
          cnt[p]  <= cnt[p] + 1'b1;
        end
        case ({push[p], pop[p]})
          2'b10:   occ[p] <= occ[p] + 1'b1;
          2'b01:   occ[p] <= occ[p] - 1'b1;
          default: occ[p] <= occ[p];
        endcase
      end
    end
  end

endmodule
